mem_access_stage: RTL and testbench

Pipeline MEM stage that sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. It consumes the registered ALU result, destination register, control flags and bubble flag. For loads and stores it runs a request/acknowledge transaction with data memory, performing byte-lane steering and sign/zero extension. It stalls the front of the pipeline until the transaction completes and presents a registered writeback packet.

---
 rtl/mem_access_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs the data-memory req/ack handshake for loads and stores,
// steers byte lanes, sign/zero-extends load data and registers the writeback packet.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_flag_i,
    input  logic [31:0] result_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_i,
    input  logic        wb_en_i,
    input  logic        read_en_i,
    input  logic        update_en_i,
    input  logic [2:0]  size_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_wstrb_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        mem_stall_o,
    output logic        misalign_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  rd_o,
    output logic        wb_en_o,
    output logic        s_flag_o
);
    localparam int NUM_LANES = 4;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [4:0]  rd;
        logic [2:0]  size;
        logic [1:0]  lane;
        logic        wb_en;
    } mem_req_t;

    state_t   state, state_nxt;
    mem_req_t req_q, req_d;
    logic     mem_op, is_store, misaligned, start_op, misalign_op;
    logic [NUM_LANES-1:0][7:0] st_lanes;
    logic [NUM_LANES-1:0]      st_strb;
    logic [31:0] ld_shift, ld_data;

    // A valid slot with both enables set is a store.
    assign mem_op   = !s_flag_i && (read_en_i || update_en_i);
    assign is_store = update_en_i;

    always_comb begin
        misaligned = 1'b0;
        case (size_i[1:0])
            2'b01:   misaligned = result_i[0];
            2'b10:   misaligned = |result_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign start_op    = (state == S_IDLE) && mem_op && !misaligned;
    assign misalign_op = (state == S_IDLE) && mem_op && misaligned;

    // Store steering: replicate the datum into every lane, strobe only the addressed ones.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam int HLO = 8 * (g % 2);
        assign st_lanes[g] = (size_i[1:0] == 2'b00) ? store_data_i[7:0] :
                             (size_i[1:0] == 2'b01) ? store_data_i[HLO +: 8] :
                                                      store_data_i[8*g +: 8];
        assign st_strb[g]  = is_store &
                             ((size_i[1:0] == 2'b00) ? (result_i[1:0] == 2'(g)) :
                              (size_i[1:0] == 2'b01) ? (result_i[1] == (g >= 2)) :
                                                       1'b1);
    end

    always_comb begin
        req_d       = '0;
        req_d.addr  = {result_i[31:2], 2'b00};
        req_d.we    = is_store;
        req_d.wdata = st_lanes;
        req_d.wstrb = st_strb;
        req_d.rd    = rd_i;
        req_d.size  = size_i;
        req_d.lane  = result_i[1:0];
        req_d.wb_en = wb_en_i;
    end

    assign ld_shift = dmem_rdata_i >> {req_q.lane, 3'b000};

    always_comb begin
        case (req_q.size)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_op)   state_nxt = S_WAIT;
            S_WAIT:  if (dmem_ack_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_req_o  = (state == S_WAIT);
        mem_stall_o = start_op || ((state == S_WAIT) && !dmem_ack_i);
    end

    // The latched request drives the memory port so it stays stable while the FSM waits.
    assign dmem_we_o    = req_q.we;
    assign dmem_addr_o  = req_q.addr;
    assign dmem_wdata_o = req_q.wdata;
    assign dmem_wstrb_o = req_q.wstrb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= '0;
            misalign_o <= 1'b0;
            wb_data_o  <= '0;
            rd_o       <= '0;
            wb_en_o    <= 1'b0;
            s_flag_o   <= 1'b1;
        end else begin
            misalign_o <= misalign_op;
            if (start_op) req_q <= req_d;
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        wb_data_o <= '0;
                        rd_o      <= rd_i;
                        wb_en_o   <= 1'b0;
                        s_flag_o  <= 1'b1;
                    end else begin
                        wb_data_o <= result_i;
                        rd_o      <= rd_i;
                        wb_en_o   <= wb_en_i;
                        s_flag_o  <= s_flag_i;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack_i) begin
                        rd_o     <= req_q.rd;
                        s_flag_o <= 1'b0;
                        if (req_q.we) begin
                            wb_data_o <= '0;
                            wb_en_o   <= 1'b0;
                        end else begin
                            wb_data_o <= ld_data;
                            wb_en_o   <= req_q.wb_en;
                        end
                    end else begin
                        wb_en_o  <= 1'b0;
                        s_flag_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector tables, a writeback scoreboard and
// hand-written misalign / mid-transaction reset sequences.
module tb_mem_access_stage;
    logic        clk, rst_n;
    logic        s_flag_i, wb_en_i, read_en_i, update_en_i;
    logic [31:0] result_i, store_data_i;
    logic [4:0]  rd_i;
    logic [2:0]  size_i;
    logic        dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_wstrb_o;
    logic        mem_stall_o, misalign_o, wb_en_o, s_flag_o;
    logic [31:0] wb_data_o;
    logic [4:0]  rd_o;

    mem_access_stage dut (
        .clk(clk), .rst_n(rst_n), .s_flag_i(s_flag_i), .result_i(result_i),
        .store_data_i(store_data_i), .rd_i(rd_i), .wb_en_i(wb_en_i),
        .read_en_i(read_en_i), .update_en_i(update_en_i), .size_i(size_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .mem_stall_o(mem_stall_o), .misalign_o(misalign_o), .wb_data_o(wb_data_o),
        .rd_o(rd_o), .wb_en_o(wb_en_o), .s_flag_o(s_flag_o)
    );

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        wb_en;
    } exp_t;

    typedef struct {
        logic        s_flag;
        logic        rd_en;
        logic        ack;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wb_en;
    } nvec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [2:0]  size;
        logic        ld;
        logic        st;
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          k;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
        logic        e_wb_en;
    } mvec_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    nvec_t nv[5];
    mvec_t mv[12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bubble();
        s_flag_i     = 1'b1;
        read_en_i    = 1'b0;
        update_en_i  = 1'b0;
        result_i     = 32'hDEAD_0000;
        store_data_i = 32'h0;
        rd_i         = 5'd0;
        wb_en_i      = 1'b0;
        size_i       = 3'b000;
    endtask

    // Scoreboard: every valid retirement must match the oldest expected packet.
    always @(negedge clk) begin
        if (rst_n && s_flag_o == 1'b0) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_retire", 32'(s_flag_o), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_wb_data", wb_data_o, e.wb_data);
                chk("sb_rd", 32'(rd_o), 32'(e.rd));
                chk("sb_wb_en", 32'(wb_en_o), 32'(e.wb_en));
            end
        end
    end

    task automatic run_mem(input mvec_t m);
        exp_t e;
        int   stalls;
        s_flag_i     = 1'b0;
        read_en_i    = m.ld;
        update_en_i  = m.st;
        result_i     = m.addr;
        store_data_i = m.sdata;
        size_i       = m.size;
        rd_i         = m.rd;
        wb_en_i      = m.wb_en;
        e.wb_data = m.e_wb;
        e.rd      = m.rd;
        e.wb_en   = m.e_wb_en;
        sb.push_back(e);
        #1;
        chk("mem_stall_issue", 32'(mem_stall_o), 32'd1);
        stalls = 1;
        for (int i = 1; i <= m.k; i++) begin
            tick();
            if (i == 1) begin
                drive_bubble();
                store_data_i = ~m.sdata;
            end
            chk("req_high", 32'(dmem_req_o), 32'd1);
            chk("req_addr", dmem_addr_o, m.e_addr);
            chk("req_we", 32'(dmem_we_o), 32'(m.e_we));
            chk("req_wstrb", 32'(dmem_wstrb_o), 32'(m.e_wstrb));
            if (m.e_we) chk("req_wdata", dmem_wdata_o, m.e_wdata);
            chk("wait_bubble", 32'(s_flag_o), 32'd1);
            dmem_ack_i   = (i == m.k);
            dmem_rdata_i = (i == m.k) ? m.rdata : 32'hBAD0_BAD0;
            #1;
            if (mem_stall_o) stalls++;
        end
        chk("stall_cycles", 32'(stalls), 32'(m.k));
        tick();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'hBAD0_BAD0;
        chk("req_drop", 32'(dmem_req_o), 32'd0);
        chk("retire_valid", 32'(s_flag_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nv[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_1234, 5'd5,  1'b1};
        nv[1] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0};
        nv[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_AAAA, 5'd3,  1'b1};
        nv[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_5555, 5'd7,  1'b1};
        nv[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'd0,  1'b1};

        mv[0]  = '{32'h103, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd1, 32'h80FF_FF7F, 3,
                   32'h100, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b1};
        mv[1]  = '{32'h103, 32'h0, 3'b100, 1'b1, 1'b0, 1'b1, 5'd2, 32'h80FF_FF7F, 1,
                   32'h100, 1'b0, 4'b0000, 32'h0, 32'h0000_0080, 1'b1};
        mv[2]  = '{32'h202, 32'hDEAD_BEEF, 3'b001, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0, 1,
                   32'h200, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0};
        mv[3]  = '{32'h102, 32'h0, 3'b001, 1'b1, 1'b0, 1'b1, 5'd4, 32'h80FF_FF7F, 2,
                   32'h100, 1'b0, 4'b0000, 32'h0, 32'hFFFF_80FF, 1'b1};
        mv[4]  = '{32'h100, 32'h0, 3'b101, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234_8001, 1,
                   32'h100, 1'b0, 4'b0000, 32'h0, 32'h0000_8001, 1'b1};
        mv[5]  = '{32'h101, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_7F00, 1,
                   32'h100, 1'b0, 4'b0000, 32'h0, 32'h0000_007F, 1'b1};
        mv[6]  = '{32'h301, 32'h1234_56A5, 3'b000, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 2,
                   32'h300, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0};
        mv[7]  = '{32'h404, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1, 1'b0, 5'd8, 32'h0, 1,
                   32'h404, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0};
        mv[8]  = '{32'h000, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd9, 32'h1111_1111, 2,
                   32'h000, 1'b0, 4'b0000, 32'h0, 32'h1111_1111, 1'b1};
        mv[9]  = '{32'h004, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd10, 32'h2222_2222, 2,
                   32'h004, 1'b0, 4'b0000, 32'h0, 32'h2222_2222, 1'b1};
        mv[10] = '{32'h300, 32'h0000_00FF, 3'b000, 1'b1, 1'b1, 1'b1, 5'd11, 32'h7777_7777, 1,
                   32'h300, 1'b1, 4'b0001, 32'hFFFF_FFFF, 32'h0, 1'b0};
        mv[11] = '{32'h200, 32'h0000_BEEF, 3'b001, 1'b0, 1'b1, 1'b0, 5'd12, 32'h0, 1,
                   32'h200, 1'b1, 4'b0011, 32'hBEEF_BEEF, 32'h0, 1'b0};

        rst_n        = 1'b0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'h0;
        drive_bubble();
        tick();
        tick();
        chk("rst_s_flag", 32'(s_flag_o), 32'd1);
        chk("rst_wb_en", 32'(wb_en_o), 32'd0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_stall", 32'(mem_stall_o), 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        chk("rst_addr", dmem_addr_o, 32'h0);
        chk("rst_wb_data", wb_data_o, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            s_flag_i   = nv[i].s_flag;
            read_en_i  = nv[i].rd_en;
            result_i   = nv[i].result;
            rd_i       = nv[i].rd;
            wb_en_i    = nv[i].wb_en;
            dmem_ack_i = nv[i].ack;
            if (!nv[i].s_flag) begin
                exp_t e;
                e.wb_data = nv[i].result;
                e.rd      = nv[i].rd;
                e.wb_en   = nv[i].wb_en;
                sb.push_back(e);
            end
            #1;
            chk("alu_stall", 32'(mem_stall_o), 32'd0);
            tick();
            dmem_ack_i = 1'b0;
            chk("alu_s_flag", 32'(s_flag_o), 32'(nv[i].s_flag));
            chk("alu_rd", 32'(rd_o), 32'(nv[i].rd));
            chk("alu_no_req", 32'(dmem_req_o), 32'd0);
        end
        drive_bubble();
        tick();

        for (int i = 0; i < 12; i++) run_mem(mv[i]);
        drive_bubble();
        tick();

        // Misaligned LW and LH: bubble out, one-cycle misalign pulse, no request.
        for (int i = 0; i < 2; i++) begin
            s_flag_i  = 1'b0;
            read_en_i = 1'b1;
            wb_en_i   = 1'b1;
            rd_i      = 5'd13;
            result_i  = (i == 0) ? 32'h101 : 32'h103;
            size_i    = (i == 0) ? 3'b010 : 3'b001;
            #1;
            chk("mis_stall", 32'(mem_stall_o), 32'd0);
            tick();
            drive_bubble();
            chk("mis_pulse", 32'(misalign_o), 32'd1);
            chk("mis_no_req", 32'(dmem_req_o), 32'd0);
            chk("mis_s_flag", 32'(s_flag_o), 32'd1);
            chk("mis_wb_en", 32'(wb_en_o), 32'd0);
            tick();
            chk("mis_pulse_end", 32'(misalign_o), 32'd0);
            chk("mis_no_req2", 32'(dmem_req_o), 32'd0);
        end

        // Reset in the middle of a WAIT abandons the transaction.
        s_flag_i  = 1'b0;
        read_en_i = 1'b1;
        wb_en_i   = 1'b1;
        rd_i      = 5'd14;
        result_i  = 32'h8;
        size_i    = 3'b010;
        tick();
        drive_bubble();
        chk("rw_req_up", 32'(dmem_req_o), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rw_req_async", 32'(dmem_req_o), 32'd0);
        chk("rw_s_flag", 32'(s_flag_o), 32'd1);
        chk("rw_wb_en", 32'(wb_en_o), 32'd0);
        chk("rw_stall", 32'(mem_stall_o), 32'd0);
        chk("rw_addr", dmem_addr_o, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rw_idle_req", 32'(dmem_req_o), 32'd0);
        run_mem('{32'h008, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd14, 32'h5A5A_5A5A, 2,
                  32'h008, 1'b0, 4'b0000, 32'h0, 32'h5A5A_5A5A, 1'b1});
        drive_bubble();
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
